oc_agreement_monitor: RTL and testbench
=======================================

// Module: oc_agreement_monitor
// PURPOSE
//  Clocked response-side checker for the 3-input open-collector gate benches.
//  Receives the stimulus vector {a,b,c} and the y0/y1 outputs of N_IMPL
//  parallel implementations (gate, primitive, assign). Waits for settling after
//  every stimulus change, then checks that all implementations agree.
//  Reports mismatch/vector counts and a final pass flag. Consumes what the
//  stimulus side drives; it is not a driver.
// PARAMETERS
//  N_IMPL        3  number of implementations compared (>=2)
//  SETTLE_CYCLES 4  stable-stimulus cycles required before sampling (>=1)
//  CNT_W         8  width of mismatch_cnt and vec_cnt
// PORTS
//  clk           in   1          rising-edge clock
//  rst_n         in   1          async active-low reset
//  start         in   1          1-cycle pulse: clear counters, begin monitoring
//  stop          in   1          1-cycle pulse: end monitoring, publish verdict
//  abc_in        in   3          stimulus vector {a,b,c}
//  y0_in         in   N_IMPL     y0 of each implementation, bit i = impl i
//  y1_in         in   N_IMPL     y1 of each implementation
//  busy          out  1          high in ARMED/SETTLE/SAMPLE
//  sample_vld    out  1          1-cycle pulse when a vector is checked
//  sample_err    out  1          valid with sample_vld: that vector mismatched
//  done          out  1          high in DONE until next start
//  pass          out  1          valid when done: mismatch_cnt==0 && vec_cnt!=0
//  mismatch_cnt  out  CNT_W      mismatching vectors, saturating
//  vec_cnt       out  CNT_W      vectors checked, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, abc_q=0, settle counter 0.
//  - States: IDLE -> (start) ARMED -> (abc_in!=abc_q) SETTLE
//    -> (cnt==SETTLE_CYCLES-1, abc stable) SAMPLE -> ARMED; any -> (stop) DONE;
//    DONE -> (start) ARMED.
//  - start: counters cleared, abc_q<=abc_in, done/pass<=0. Next state ARMED.
//    The initial vector is not checked; only changes are.
//  - SETTLE: counter counts from 0 while abc stable; any abc change restarts it
//    at 0 and reloads abc_q (glitch/back-to-back change tolerance).
//  - SAMPLE (one cycle): sample_vld=1; error iff y0_in not all-equal or
//    y1_in not all-equal (sim: any X/Z bit also counts as error).
//    vec_cnt+1, mismatch_cnt+1 on error; both saturate at 2**CNT_W-1.
//  - Latency: change seen at edge k -> sample_vld at edge k+SETTLE_CYCLES+1.
//  - stop and start in same cycle: start wins. stop in SAMPLE: that sample
//    still counts, then DONE. stop in IDLE: go DONE with pass=0.
//  - start while busy: restart (counters cleared), no DONE.
//  - rst_n low mid-operation: immediate return to reset values.
// CONFIGURATION
//  OC_FIRST_FAIL_EN defined: adds outputs first_fail_abc[2:0], first_fail_y0
//  [N_IMPL-1:0], first_fail_y1[N_IMPL-1:0], first_fail_vld; captured on first
//  error after start, held until next start/reset. Not defined: ports absent,
//  no capture registers; all else identical.
// STRUCTURE
//  Package oc_mon_pkg: state enum (IDLE,ARMED,SETTLE,SAMPLE,DONE), helper
//  function all_equal(), default SETTLE_CYCLES constant.
//  Sub-module oc_sat_counter (CNT_W, inc, clr, saturating) instantiated twice.
// TESTING
//  1 reset, start, walk abc 000->001->011->111->110 stable 10 cyc each, all
//    impls equal -> 4 sample_vld, vec_cnt=4, mismatch_cnt=0, stop -> pass=1.
//  2 force impl 1 y0 inverted on vector 011 only -> sample_err once,
//    mismatch_cnt=1, pass=0 (with OC_FIRST_FAIL_EN: first_fail_abc=3'b011).
//  3 toggle abc every 2 cyc with SETTLE_CYCLES=4, then hold -> exactly 1 sample,
//    at SETTLE_CYCLES+1 edges after last change.
//  4 CNT_W=2, 5 mismatching vectors -> mismatch_cnt=3, vec_cnt=3 (saturated).
//  5 rst_n low during SETTLE -> all outputs 0 immediately; no sample after.
//  6 start and stop same cycle -> ARMED, done=0; stop with no vectors ->
//    done=1, pass=0.

Source files
------------

// File: rtl/oc_mon_pkg.sv
// Shared state encoding and agreement helper for the open-collector agreement monitor.
package oc_mon_pkg;

  localparam int DEFAULT_SETTLE_CYCLES = 4;
  localparam int MAX_IMPL = 32;

  typedef enum logic [2:0] {IDLE, ARMED, SETTLE, SAMPLE, DONE} mon_state_e;

  // True only when the low n bits are all 0 or all 1; any X/Z bit makes it false.
  function automatic logic all_equal(input logic [MAX_IMPL-1:0] v, input int n);
    logic zeros;
    logic ones;
    zeros = 1'b1;
    ones  = 1'b1;
    for (int i = 0; i < MAX_IMPL; i++) begin
      if (i < n) begin
        if (v[i] !== 1'b0) zeros = 1'b0;
        if (v[i] !== 1'b1) ones = 1'b0;
      end
    end
    return zeros | ones;
  endfunction

endpackage

// File: rtl/oc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module oc_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/oc_agreement_monitor.sv
// Checks that N_IMPL parallel open-collector implementations agree once the stimulus settles.
// Optional first-failure capture ports are enabled by defining OC_FIRST_FAIL_EN.
module oc_agreement_monitor
  import oc_mon_pkg::*;
#(
  parameter int N_IMPL        = 3,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        abc_in,
  input  logic [N_IMPL-1:0] y0_in,
  input  logic [N_IMPL-1:0] y1_in,
  output logic              busy,
  output logic              sample_vld,
  output logic              sample_err,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
`ifdef OC_FIRST_FAIL_EN
  output logic [2:0]        first_fail_abc,
  output logic [N_IMPL-1:0] first_fail_y0,
  output logic [N_IMPL-1:0] first_fail_y1,
  output logic              first_fail_vld,
`endif
  output logic [CNT_W-1:0]  vec_cnt
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  mon_state_e    state_q, state_d;
  logic [2:0]    abc_q, abc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          sample_now;
  logic          err;

  assign err = !(all_equal(MAX_IMPL'(y0_in), N_IMPL) && all_equal(MAX_IMPL'(y1_in), N_IMPL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      abc_q      <= '0;
      cnt_q      <= '0;
      sample_vld <= 1'b0;
      sample_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      abc_q      <= abc_d;
      cnt_q      <= cnt_d;
      sample_vld <= sample_now;
      sample_err <= sample_now & err;
    end
  end

  // start overrides everything; stop is applied after the state action so a SAMPLE still counts.
  always_comb begin
    state_d    = state_q;
    abc_d      = abc_q;
    cnt_d      = cnt_q;
    sample_now = 1'b0;
    if (start) begin
      state_d = ARMED;
      abc_d   = abc_in;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (abc_in != abc_q) begin
            state_d = SETTLE;
            abc_d   = abc_in;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (abc_in != abc_q) begin
            abc_d = abc_in;
            cnt_d = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          sample_now = 1'b1;
          state_d    = ARMED;
        end
        default: ;
      endcase
      if (stop) state_d = DONE;
    end
  end

  oc_sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (sample_now & err),
    .count (mismatch_cnt)
  );

  oc_sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (sample_now),
    .count (vec_cnt)
  );

  assign busy = (state_q == ARMED) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done = (state_q == DONE);
  assign pass = done && (mismatch_cnt == '0) && (vec_cnt != '0);

`ifdef OC_FIRST_FAIL_EN
  // Only the first mismatching vector after start is kept, for post-run diagnosis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_abc <= '0;
      first_fail_y0  <= '0;
      first_fail_y1  <= '0;
      first_fail_vld <= 1'b0;
    end else if (start) begin
      first_fail_abc <= '0;
      first_fail_y0  <= '0;
      first_fail_y1  <= '0;
      first_fail_vld <= 1'b0;
    end else if (sample_now && err && !first_fail_vld) begin
      first_fail_abc <= abc_q;
      first_fail_y0  <= y0_in;
      first_fail_y1  <= y1_in;
      first_fail_vld <= 1'b1;
    end
  end
`else
  // Default build keeps no failure-capture state.
`endif

endmodule

// File: tb/tb_oc_agreement_monitor.sv
// Self-checking bench for oc_agreement_monitor: directed scenarios plus random stimulus
// against an event-deadline reference model; a CNT_W=2 copy exercises saturation.
module tb_oc_agreement_monitor;

  localparam int N = 3;
  localparam int S = 4;

  logic clk, rst_n, start, stop;
  logic [2:0] abc;
  logic [N-1:0] y0, y1, y0_flip, y1_flip;

  logic busy, sample_vld, sample_err, done, pass;
  logic [7:0] mismatch_cnt, vec_cnt;
  logic busy2, sample_vld2, sample_err2, done2, pass2;
  logic [1:0] mismatch_cnt2, vec_cnt2;
`ifdef OC_FIRST_FAIL_EN
  logic [2:0] ff_abc, ff_abc2;
  logic [N-1:0] ff_y0, ff_y1, ff_y02, ff_y12;
  logic ff_vld, ff_vld2;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int n_samples = 0;
  int n_errs = 0;
  int last_sample_cyc = 0;
  int chg_edge = 0;

  // Model state: a sample fires at a deadline edge; any unseen change pushes the deadline.
  int cyc = 0;
  int m_deadline = -1;
  int m_vec = 0;
  int m_mis = 0;
  bit m_active = 0, m_done = 0, m_sv = 0, m_se = 0;
  logic [2:0] m_ref = '0;

  assign y0 = {N{~&abc}} ^ y0_flip;
  assign y1 = {N{|abc}} ^ y1_flip;

  oc_agreement_monitor #(.N_IMPL(N), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abc_in(abc),
    .y0_in(y0), .y1_in(y1), .busy(busy), .sample_vld(sample_vld),
    .sample_err(sample_err), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
`ifdef OC_FIRST_FAIL_EN
    .first_fail_abc(ff_abc), .first_fail_y0(ff_y0), .first_fail_y1(ff_y1),
    .first_fail_vld(ff_vld),
`endif
    .vec_cnt(vec_cnt)
  );

  oc_agreement_monitor #(.N_IMPL(N), .SETTLE_CYCLES(S), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .abc_in(abc),
    .y0_in(y0), .y1_in(y1), .busy(busy2), .sample_vld(sample_vld2),
    .sample_err(sample_err2), .done(done2), .pass(pass2), .mismatch_cnt(mismatch_cnt2),
`ifdef OC_FIRST_FAIL_EN
    .first_fail_abc(ff_abc2), .first_fail_y0(ff_y02), .first_fail_y1(ff_y12),
    .first_fail_vld(ff_vld2),
`endif
    .vec_cnt(vec_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit all_same(input logic [N-1:0] v);
    int c;
    c = $countones(v);
    return (c == 0) || (c == N);
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model, evaluated on inputs as they stand at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_sv = 0; m_se = 0;
      m_ref = '0; m_deadline = -1; m_vec = 0; m_mis = 0;
    end else begin
      cyc++;
      m_sv = 0;
      m_se = 0;
      if (start) begin
        m_active = 1; m_done = 0; m_ref = abc; m_deadline = -1; m_vec = 0; m_mis = 0;
      end else begin
        if (m_active) begin
          if (m_deadline == cyc) begin
            m_sv = 1;
            m_se = !(all_same(y0) && all_same(y1));
            m_vec++;
            if (m_se) m_mis++;
            m_deadline = -1;
          end else if (abc != m_ref) begin
            m_ref = abc;
            m_deadline = cyc + S + 1;
          end
        end
        if (stop) begin
          m_active = 0; m_done = 1; m_deadline = -1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    checkOutput("busy", busy, m_active);
    checkOutput("sample_vld", sample_vld, m_sv);
    checkOutput("sample_err", sample_err, m_se);
    checkOutput("done", done, m_done);
    checkOutput("pass", pass, m_done && m_mis == 0 && m_vec != 0);
    checkOutput("mismatch_cnt", mismatch_cnt, sat(m_mis, 8));
    checkOutput("vec_cnt", vec_cnt, sat(m_vec, 8));
    checkOutput("sat_busy", busy2, m_active);
    checkOutput("sat_sample_vld", sample_vld2, m_sv);
    checkOutput("sat_sample_err", sample_err2, m_se);
    checkOutput("sat_done", done2, m_done);
    checkOutput("sat_pass", pass2, m_done && m_mis == 0 && m_vec != 0);
    checkOutput("sat_mismatch_cnt", mismatch_cnt2, sat(m_mis, 2));
    checkOutput("sat_vec_cnt", vec_cnt2, sat(m_vec, 2));
    if (sample_vld) begin
      n_samples++;
      last_sample_cyc = cyc;
    end
    if (sample_err) n_errs++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [N-1:0] f0,
                               input logic [N-1:0] f1, input int hold);
    abc = v;
    y0_flip = f0;
    y1_flip = f1;
    tick(hold);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; abc = '0; y0_flip = '0; y1_flip = '0;
    tick(3);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_vec_cnt", vec_cnt, 0);
    rst_n = 1'b1;
    tick(1);

    // 1: clean walk, four checked vectors, pass
    n_samples = 0;
    pulseStart();
    applyStimulus(3'b001, '0, '0, 10);
    applyStimulus(3'b011, '0, '0, 10);
    applyStimulus(3'b111, '0, '0, 10);
    applyStimulus(3'b110, '0, '0, 10);
    pulseStop();
    checkOutput("t1_samples", n_samples, 4);
    checkOutput("t1_vec_cnt", vec_cnt, 4);
    checkOutput("t1_model_vec", m_vec, 4);
    checkOutput("t1_mismatch_cnt", mismatch_cnt, 0);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_pass", pass, 1);

    // 2: impl 1 y0 inverted on 011 only
    n_errs = 0;
    pulseStart();
    applyStimulus(3'b111, '0, '0, 10);
    applyStimulus(3'b011, 3'b010, '0, 10);
    applyStimulus(3'b001, '0, '0, 10);
    applyStimulus(3'b000, '0, '0, 10);
    pulseStop();
    checkOutput("t2_errs", n_errs, 1);
    checkOutput("t2_mismatch_cnt", mismatch_cnt, 1);
    checkOutput("t2_model_mis", m_mis, 1);
    checkOutput("t2_pass", pass, 0);
`ifdef OC_FIRST_FAIL_EN
    checkOutput("t2_first_fail_abc", ff_abc, 3'b011);
    checkOutput("t2_first_fail_vld", ff_vld, 1);
`endif

    // 3: toggling faster than settle, then hold: one sample, fixed latency
    n_samples = 0;
    pulseStart();
    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 3'b010 : 3'b101, '0, '0, 2);
    chg_edge = cyc + 1;
    applyStimulus(3'b111, '0, '0, 12);
    checkOutput("t3_samples", n_samples, 1);
    checkOutput("t3_latency", last_sample_cyc - chg_edge, 5);
    pulseStop();

    // 4: five mismatching vectors saturate the CNT_W=2 copy
    pulseStart();
    applyStimulus(3'b001, '0, 3'b001, 8);
    applyStimulus(3'b010, '0, 3'b001, 8);
    applyStimulus(3'b100, '0, 3'b001, 8);
    applyStimulus(3'b011, '0, 3'b001, 8);
    applyStimulus(3'b101, '0, 3'b001, 8);
    pulseStop();
    checkOutput("t4_sat_mismatch_cnt", mismatch_cnt2, 3);
    checkOutput("t4_sat_vec_cnt", vec_cnt2, 3);
    checkOutput("t4_mismatch_cnt", mismatch_cnt, 5);
    checkOutput("t4_vec_cnt", vec_cnt, 5);

    // 5: reset asserted while settling
    pulseStart();
    applyStimulus(3'b110, '0, '0, 2);
    checkOutput("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy_reset", busy, 0);
    checkOutput("t5_sample_vld_reset", sample_vld, 0);
    tick(3);
    rst_n = 1'b1;
    n_samples = 0;
    tick(10);
    checkOutput("t5_no_sample", n_samples, 0);

    // 6: stop in IDLE, start+stop together, stop with no vectors
    pulseStop();
    checkOutput("t6_idle_stop_done", done, 1);
    checkOutput("t6_idle_stop_pass", pass, 0);
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    checkOutput("t6_both_busy", busy, 1);
    checkOutput("t6_both_done", done, 0);
    pulseStop();
    checkOutput("t6_empty_done", done, 1);
    checkOutput("t6_empty_pass", pass, 0);

    // Random phase: vectors, faults, hold lengths and control pulses
    pulseStart();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) pulseStop();
      else if (r == 1) pulseStart();
      else if (r == 2) begin
        start = 1'b1;
        stop = 1'b1;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
      end else begin
        applyStimulus(3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0,
                      ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 7)) : '0,
                      $urandom_range(1, 8));
      end
    end
    pulseStop();
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
